// File: rtl/and_vector_sequencer.sv
// Self-checking operand driver for the 16-bit bitwise AND stage: drives a fixed vector table,
// holds each pair HOLD_CYCLES cycles, then checks res_i. Define ANDSEQ_LFSR_EN to append LFSR vectors.
module and_vector_sequencer #(
  parameter int          WIDTH        = 16,
  parameter int          HOLD_CYCLES  = 25,
  parameter int          LFSR_VECTORS = 16,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] res_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [7:0]       first_fail_idx,
  output logic [7:0]       vec_idx
);

  localparam int FIXED_VECTORS = 6;
`ifdef ANDSEQ_LFSR_EN
  localparam int NUM_VECTORS = FIXED_VECTORS + LFSR_VECTORS;
`else
  localparam int NUM_VECTORS = FIXED_VECTORS;
`endif
  localparam logic [7:0] LAST_IDX = 8'(NUM_VECTORS - 1);
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  // Index 8'hFF doubles as the "no failure" marker, so at most 255 vectors are allowed.
  generate
    if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("HOLD_CYCLES must be at least 1");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
      $error("LFSR_SEED must be non-zero");
    end
    if (LFSR_VECTORS < 0 || NUM_VECTORS > 255) begin : g_bad_count
      $error("vector count out of range");
    end
`ifdef ANDSEQ_LFSR_EN
    if (WIDTH != 16) begin : g_bad_width
      $error("WIDTH must be 16 when the LFSR vectors are enabled");
    end
`endif
  endgenerate

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } vec_t;

  function automatic vec_t fixed_vector(input logic [7:0] idx);
    vec_t             v;
    logic [WIDTH-1:0] alt;
    for (int i = 0; i < WIDTH; i++) begin
      alt[i] = ((WIDTH - 1 - i) % 2) == 0;
    end
    v = '0;
    case (idx)
      8'd1:    v.a = WIDTH'(1);
      8'd2:    v.b = WIDTH'(1);
      8'd3:    begin v.a = WIDTH'(1); v.b = WIDTH'(1); end
      8'd4:    begin v.a = '1;        v.b = '1;        end
      8'd5:    begin v.a = alt;       v.b = '1;        end
      default: v = '0;
    endcase
    return v;
  endfunction

`ifdef ANDSEQ_LFSR_EN
  // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting toward bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  logic [15:0] lfsr, lfsr_nxt;
`endif

  state_t           state, state_nxt;
  logic [CNT_W-1:0] hold_cnt, cnt_nxt;
  logic [WIDTH-1:0] a_nxt, b_nxt;
  logic             busy_nxt, done_nxt, pass_nxt;
  logic [7:0]       err_nxt, ffi_nxt, idx_nxt;
  vec_t             next_vec;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = hold_cnt;
    a_nxt     = a_o;
    b_nxt     = b_o;
    busy_nxt  = busy;
    done_nxt  = done;
    pass_nxt  = pass;
    err_nxt   = err_count;
    ffi_nxt   = first_fail_idx;
    idx_nxt   = vec_idx;
    next_vec  = '0;
`ifdef ANDSEQ_LFSR_EN
    lfsr_nxt  = lfsr;
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          next_vec  = fixed_vector(8'd0);
          a_nxt     = next_vec.a;
          b_nxt     = next_vec.b;
          err_nxt   = 8'd0;
          ffi_nxt   = 8'hFF;
          idx_nxt   = 8'd0;
          done_nxt  = 1'b0;
          pass_nxt  = 1'b0;
          busy_nxt  = 1'b1;
          cnt_nxt   = HOLD_LOAD;
          state_nxt = DRIVE;
`ifdef ANDSEQ_LFSR_EN
          lfsr_nxt  = LFSR_SEED;
`endif
        end
      end
      DRIVE: begin
        if (abort) begin
          state_nxt = IDLE;
          a_nxt     = '0;
          b_nxt     = '0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b0;
          pass_nxt  = 1'b0;
        end else if (hold_cnt == '0) begin
          state_nxt = CHECK;
        end else begin
          cnt_nxt = hold_cnt - CNT_W'(1);
        end
      end
      CHECK: begin
        // An abort here discards the check, so the current vector is never counted.
        if (abort) begin
          state_nxt = IDLE;
          a_nxt     = '0;
          b_nxt     = '0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b0;
          pass_nxt  = 1'b0;
        end else begin
          if (res_i != (a_o & b_o)) begin
            if (err_count != 8'hFF) err_nxt = err_count + 8'd1;
            if (first_fail_idx == 8'hFF) ffi_nxt = vec_idx;
          end
`ifdef ANDSEQ_LFSR_EN
          if (vec_idx >= 8'(FIXED_VECTORS)) lfsr_nxt = lfsr_step(lfsr);
`endif
          if (vec_idx == LAST_IDX) begin
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            pass_nxt  = (err_nxt == 8'd0);
          end else begin
            idx_nxt = vec_idx + 8'd1;
`ifdef ANDSEQ_LFSR_EN
            if (idx_nxt >= 8'(FIXED_VECTORS))
              next_vec = '{a: WIDTH'(lfsr_nxt), b: WIDTH'({lfsr_nxt[7:0], lfsr_nxt[15:8]})};
            else
`endif
              next_vec = fixed_vector(idx_nxt);
            a_nxt     = next_vec.a;
            b_nxt     = next_vec.b;
            cnt_nxt   = HOLD_LOAD;
            state_nxt = DRIVE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      hold_cnt       <= '0;
      a_o            <= '0;
      b_o            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= 8'd0;
      first_fail_idx <= 8'hFF;
      vec_idx        <= 8'd0;
`ifdef ANDSEQ_LFSR_EN
      lfsr           <= LFSR_SEED;
`endif
    end else begin
      state          <= state_nxt;
      hold_cnt       <= cnt_nxt;
      a_o            <= a_nxt;
      b_o            <= b_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
      pass           <= pass_nxt;
      err_count      <= err_nxt;
      first_fail_idx <= ffi_nxt;
      vec_idx        <= idx_nxt;
`ifdef ANDSEQ_LFSR_EN
      lfsr           <= lfsr_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_and_vector_sequencer.sv
// Scoreboard bench for and_vector_sequencer: expected vectors and run results are queued at
// start, and a negedge monitor pops them as the DUT presents each vector and each done.
module tb_and_vector_sequencer;

  localparam int HOLD = 25;
`ifdef ANDSEQ_LFSR_EN
  localparam int NV = 6 + 16;
`else
  localparam int NV = 6;
`endif
  localparam int RUN_CYCLES = NV * (HOLD + 1);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] res_i, a_o, b_o;
  logic        busy, done, pass;
  logic [7:0]  err_count, first_fail_idx, vec_idx;
  logic [15:0] faultMask = 16'hFFFF;

  // The AND stage under test, with an optional stuck-at-0 fault mask on its result.
  assign res_i = a_o & b_o & faultMask;

  always #5 clk = ~clk;

  and_vector_sequencer #(.WIDTH(16), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .res_i(res_i),
    .a_o(a_o), .b_o(b_o), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_idx(first_fail_idx), .vec_idx(vec_idx)
  );

  typedef struct {
    logic [7:0]  idx;
    logic [15:0] a;
    logic [15:0] b;
  } vecExp_t;

  typedef struct {
    logic       passExp;
    logic [7:0] errExp;
    logic [7:0] ffiExp;
    int         latency;
  } resExp_t;

  vecExp_t vecQ[$];
  resExp_t resQ[$];
  int compareCount = 0;
  int mismatchCount = 0;
  int cycleCnt = 0;
  int runStart = 0;
  int lastChange = 0;
  logic prevBusy = 1'b0;
  logic prevDone = 1'b0;
  logic [7:0] prevVec = 8'd0;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  function automatic vecExp_t expVector(int idx);
    vecExp_t v;
    logic [15:0] s;
    v.idx = 8'(idx);
    case (idx)
      0: begin v.a = 16'h0000; v.b = 16'h0000; end
      1: begin v.a = 16'h0001; v.b = 16'h0000; end
      2: begin v.a = 16'h0000; v.b = 16'h0001; end
      3: begin v.a = 16'h0001; v.b = 16'h0001; end
      4: begin v.a = 16'hFFFF; v.b = 16'hFFFF; end
      5: begin v.a = 16'hAAAA; v.b = 16'hFFFF; end
      default: begin
        s = 16'hACE1;
        for (int i = 6; i < idx; i++) s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
        v.a = s;
        v.b = {s[7:0], s[15:8]};
      end
    endcase
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic doStart, input logic doAbort);
    @(negedge clk);
    start = doStart;
    abort = doAbort;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Queues the full expected run for the current fault mask, then pulses start.
  task automatic issueRun(input logic withAbort);
    vecExp_t v;
    resExp_t r;
    logic [15:0] good;
    r.errExp = 8'd0;
    r.ffiExp = 8'hFF;
    for (int i = 0; i < NV; i++) begin
      v = expVector(i);
      vecQ.push_back(v);
      good = v.a & v.b;
      if ((good & faultMask) != good) begin
        if (r.errExp != 8'hFF) r.errExp = r.errExp + 8'd1;
        if (r.ffiExp == 8'hFF) r.ffiExp = 8'(i);
      end
    end
    r.passExp = (r.errExp == 8'd0);
    r.latency = RUN_CYCLES;
    resQ.push_back(r);
    applyStimulus(1'b1, withAbort);
    runStart = cycleCnt;
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    @(negedge clk);
    while (!done && n < RUN_CYCLES + 20) begin
      @(negedge clk);
      n++;
    end
    compareCount++;
    if (!done) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got timeout, expected done=1", name);
    end
  endtask

  task automatic waitVec(input string name, input logic [7:0] idx);
    int n = 0;
    @(negedge clk);
    while (!(busy && vec_idx == idx) && n < RUN_CYCLES + 20) begin
      @(negedge clk);
      n++;
    end
    compareCount++;
    if (!(busy && vec_idx == idx)) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got timeout, expected vec_idx=%0d while busy", name, idx);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_a"}, 32'(a_o), 32'h0);
    checkOutput({tag, "_b"}, 32'(b_o), 32'h0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
    checkOutput({tag, "_done"}, 32'(done), 32'h0);
    checkOutput({tag, "_pass"}, 32'(pass), 32'h0);
    checkOutput({tag, "_err"}, 32'(err_count), 32'h0);
    checkOutput({tag, "_ffi"}, 32'(first_fail_idx), 32'hFF);
    checkOutput({tag, "_vec"}, 32'(vec_idx), 32'h0);
  endtask

  // Monitor: every newly presented vector and every rising done is matched against the queues.
  always @(negedge clk) begin
    vecExp_t e;
    resExp_t r;
    if (busy && (!prevBusy || vec_idx != prevVec)) begin
      if (prevBusy) checkOutput("hold_len", 32'(cycleCnt - lastChange), 32'(HOLD + 1));
      lastChange = cycleCnt;
      if (vecQ.size() == 0) begin
        compareCount++;
        mismatchCount++;
        $display("[TB] FAIL unexpected_vector: got vec_idx=%0d, expected none", vec_idx);
      end else begin
        e = vecQ.pop_front();
        checkOutput("vec_idx", 32'(vec_idx), 32'(e.idx));
        checkOutput("vec_a", 32'(a_o), 32'(e.a));
        checkOutput("vec_b", 32'(b_o), 32'(e.b));
      end
    end
    if (done && !prevDone) begin
      if (resQ.size() == 0) begin
        compareCount++;
        mismatchCount++;
        $display("[TB] FAIL unexpected_done: got done=1, expected none");
      end else begin
        r = resQ.pop_front();
        checkOutput("res_pass", 32'(pass), 32'(r.passExp));
        checkOutput("res_err", 32'(err_count), 32'(r.errExp));
        checkOutput("res_ffi", 32'(first_fail_idx), 32'(r.ffiExp));
        checkOutput("res_latency", 32'(cycleCnt - runStart), 32'(r.latency));
      end
    end
    prevBusy = busy;
    prevDone = done;
    prevVec  = vec_idx;
  end

  initial begin
    vecExp_t last;
    last = expVector(NV - 1);

    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;

    // Clean run with a correct AND stage.
    faultMask = 16'hFFFF;
    issueRun(1'b0);
    waitDone("run1_done");
    checkOutput("run1_vectors_left", 32'(vecQ.size()), 32'h0);
    checkOutput("run1_hold_a", 32'(a_o), 32'(last.a));
    checkOutput("run1_hold_b", 32'(b_o), 32'(last.b));
    checkOutput("run1_busy", 32'(busy), 32'h0);

    // Abort in DONE must do nothing.
    applyStimulus(1'b0, 1'b1);
    checkOutput("done_abort_done", 32'(done), 32'h1);
    checkOutput("done_abort_pass", 32'(pass), 32'h1);

    // Result bit0 stuck at 0, plus a start pulse while busy that must be ignored.
    faultMask = 16'hFFFE;
    issueRun(1'b0);
    waitVec("run2_vec1", 8'd1);
    applyStimulus(1'b1, 1'b0);
    waitDone("run2_done");

    // Restart from DONE clears the previous run's results, then abort during vector 5.
    issueRun(1'b0);
    checkOutput("run3_clr_err", 32'(err_count), 32'h0);
    checkOutput("run3_clr_ffi", 32'(first_fail_idx), 32'hFF);
    checkOutput("run3_clr_done", 32'(done), 32'h0);
    checkOutput("run3_busy", 32'(busy), 32'h1);
    checkOutput("run3_vec0", 32'(vec_idx), 32'h0);
    waitVec("run3_vec5", 8'd5);
    repeat (3) @(negedge clk);
    vecQ.delete();
    resQ.delete();
    applyStimulus(1'b0, 1'b1);
    checkOutput("abort5_busy", 32'(busy), 32'h0);
    checkOutput("abort5_done", 32'(done), 32'h0);
    checkOutput("abort5_a", 32'(a_o), 32'h0);
    checkOutput("abort5_err_kept", 32'(err_count), 32'h2);
    checkOutput("abort5_ffi_kept", 32'(first_fail_idx), 32'h3);

    // Abort during DRIVE of vector 2 with a correct AND stage.
    faultMask = 16'hFFFF;
    issueRun(1'b0);
    waitVec("run4_vec2", 8'd2);
    repeat (5) @(negedge clk);
    vecQ.delete();
    resQ.delete();
    applyStimulus(1'b0, 1'b1);
    checkOutput("abort2_busy", 32'(busy), 32'h0);
    checkOutput("abort2_done", 32'(done), 32'h0);
    checkOutput("abort2_pass", 32'(pass), 32'h0);
    checkOutput("abort2_a", 32'(a_o), 32'h0);
    checkOutput("abort2_b", 32'(b_o), 32'h0);
    repeat (HOLD + 3) @(negedge clk);
    checkOutput("abort2_stays_idle", 32'(busy), 32'h0);

    // Start and abort together from IDLE: start wins and the full sequence runs.
    issueRun(1'b1);
    waitDone("run5_done");
    checkOutput("run5_vectors_left", 32'(vecQ.size()), 32'h0);

    // Asynchronous reset mid-DRIVE of vector 1, away from any clock edge.
    issueRun(1'b0);
    waitVec("run6_vec1", 8'd1);
    @(negedge clk);
    vecQ.delete();
    resQ.delete();
    #3;
    rst_n = 1'b0;
    #1;
    checkResetValues("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
